// File: rtl/alu_sequencer_pkg.sv
// Shared ISA definitions for the ALU sequencer: widths, opcodes, flag layout, sequencer states.
// Codes 11..15 of eOperation are unassigned and complete as no-ops.
package InstructionSetPkg;

  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;
  localparam int MulDivLatency  = 4;

  typedef enum logic [3:0] {
    OP_ADC  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_MOVE = 4'd6,
    OP_MUL  = 4'd7,
    OP_MUH  = 4'd8,
    OP_DIV  = 4'd9,
    OP_MOD  = 4'd10
  } eOperation;

  typedef struct packed {
    logic Negative;
    logic Zero;
    logic Carry;
    logic Overflow;
  } sFlags;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } eSeqState;

  function automatic logic IsMulDiv(input eOperation op);
    return op inside {OP_MUL, OP_MUH, OP_DIV, OP_MOD};
  endfunction

  function automatic logic IsDivide(input eOperation op);
    return op inside {OP_DIV, OP_MOD};
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Purely combinational ALU: Dest op Src (or Dest + sign-extended Imm), result and post-op flags.
// No state, no handshake; the sequencer decides when the outputs are captured.
module ArithmeticLogicUnit
  import InstructionSetPkg::*;
(
  input  eOperation                 Op,
  input  logic [DataWidth-1:0]      Src,
  input  logic [DataWidth-1:0]      Dest,
  input  logic [ImmediateWidth-1:0] Imm,
  input  sFlags                     InFlags,
  output logic [DataWidth-1:0]      OutDest,
  output sFlags                     OutFlags
);

  localparam int Msb = DataWidth - 1;

  logic [DataWidth-1:0]   imm_ext;
  logic [DataWidth-1:0]   operand_b;
  logic [DataWidth-1:0]   result;
  logic [DataWidth:0]     sum;
  logic [2*DataWidth-1:0] product;
  logic                   known;

  assign imm_ext   = {{(DataWidth-ImmediateWidth){Imm[ImmediateWidth-1]}}, Imm};
  assign operand_b = (Op == OP_ADDI) ? imm_ext : Src;
  assign product   = {{DataWidth{1'b0}}, Dest} * {{DataWidth{1'b0}}, Src};
  assign OutDest   = result;

  always_comb begin
    result   = '0;
    sum      = '0;
    known    = 1'b1;
    OutFlags = InFlags;
    case (Op)
      OP_ADC, OP_ADDI: begin
        sum = {1'b0, Dest} + {1'b0, operand_b}
            + {{DataWidth{1'b0}}, (Op == OP_ADC) && InFlags.Carry};
        result            = sum[Msb:0];
        OutFlags.Carry    = sum[DataWidth];
        OutFlags.Overflow = (Dest[Msb] == operand_b[Msb]) && (result[Msb] != Dest[Msb]);
      end
      OP_SUB: begin
        // Carry reports a borrow out of the subtraction.
        sum               = {1'b0, Dest} - {1'b0, Src};
        result            = sum[Msb:0];
        OutFlags.Carry    = sum[DataWidth];
        OutFlags.Overflow = (Dest[Msb] != Src[Msb]) && (result[Msb] != Dest[Msb]);
      end
      OP_AND:  result = Dest & Src;
      OP_OR:   result = Dest | Src;
      OP_XOR:  result = Dest ^ Src;
      OP_MOVE: result = Src;
      OP_MUL, OP_MUH, OP_DIV, OP_MOD: begin
        OutFlags.Carry    = 1'b0;
        OutFlags.Overflow = 1'b0;
        case (Op)
          OP_MUL:  result = product[Msb:0];
          OP_MUH:  result = product[2*DataWidth-1:DataWidth];
          OP_DIV:  result = (Src == '0) ? '0 : Dest / Src;
          default: result = (Src == '0) ? '0 : Dest % Src;
        endcase
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      OutFlags.Negative = result[Msb];
      OutFlags.Zero     = (result == '0);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU op at a time: 1 cycle accept->RspValid, MulDivLatency cycles for MUL/MUH/DIV/MOD.
// New requests only in IDLE or on the response handshake edge; RESP holds until RspReady.
module alu_sequencer #(
  parameter int MulDivLatency = InstructionSetPkg::MulDivLatency
) (
  input  logic                                       Clock,
  input  logic                                       Reset,
  input  logic                                       ReqValid,
  output logic                                       ReqReady,
  input  InstructionSetPkg::eOperation               ReqOp,
  input  logic [InstructionSetPkg::DataWidth-1:0]      ReqSrc,
  input  logic [InstructionSetPkg::DataWidth-1:0]      ReqDest,
  input  logic [InstructionSetPkg::ImmediateWidth-1:0] ReqImm,
  output logic                                       RspValid,
  input  logic                                       RspReady,
  output logic [InstructionSetPkg::DataWidth-1:0]      RspDest,
  output InstructionSetPkg::sFlags                   RspFlags,
  output logic                                       RspError,
  input  logic                                       Flush,
  output InstructionSetPkg::sFlags                   Flags,
  output logic                                       Busy
);

  import InstructionSetPkg::*;

  eSeqState                  state;
  logic [3:0]                count;
  eOperation                 op_q;
  logic [DataWidth-1:0]      src_q;
  logic [DataWidth-1:0]      dest_q;
  logic [ImmediateWidth-1:0] imm_q;
  sFlags                     flags_q;
  logic [DataWidth-1:0]      alu_dest;
  sFlags                     alu_flags;
  logic                      accept;
  logic                      complete;
  logic                      div_zero;

  assign ReqReady = ((state == IDLE) || ((state == RESP) && RspReady)) && !Flush;
  assign accept   = ReqValid && ReqReady;
  assign complete = (state == EXEC) || ((state == WAIT) && (count == '0));
  assign div_zero = IsDivide(op_q) && (src_q == '0);
  assign Busy     = (state != IDLE);
  assign Flags    = flags_q;

  ArithmeticLogicUnit u_alu (
    .Op       (op_q),
    .Src      (src_q),
    .Dest     (dest_q),
    .Imm      (imm_q),
    .InFlags  (flags_q),
    .OutDest  (alu_dest),
    .OutFlags (alu_flags)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= '0;
      op_q     <= OP_ADC;
      src_q    <= '0;
      dest_q   <= '0;
      imm_q    <= '0;
      flags_q  <= '0;
      RspValid <= 1'b0;
      RspDest  <= '0;
      RspFlags <= '0;
      RspError <= 1'b0;
    end else if (Flush) begin
      state    <= IDLE;
      count    <= '0;
      RspValid <= 1'b0;
    end else begin
      if (complete) begin
        state    <= RESP;
        RspValid <= 1'b1;
        if (div_zero) begin
          RspDest  <= '0;
          RspError <= 1'b1;
          RspFlags <= flags_q;
        end else begin
          RspDest  <= alu_dest;
          RspError <= 1'b0;
          RspFlags <= alu_flags;
          flags_q  <= alu_flags;
        end
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end

      if ((state == RESP) && RspReady) begin
        RspValid <= 1'b0;
        state    <= IDLE;
      end

      // Accept overrides the RESP->IDLE step so back-to-back ops lose no cycle.
      if (accept) begin
        op_q   <= ReqOp;
        src_q  <= ReqSrc;
        dest_q <= ReqDest;
        imm_q  <= ReqImm;
        if (IsMulDiv(ReqOp) && !(IsDivide(ReqOp) && (ReqSrc == '0))) begin
          state <= WAIT;
          count <= 4'(MulDivLatency - 1);
        end else begin
          state <= EXEC;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboarded bench: requests push model expectations at accept, an independent monitor checks responses.
module tb_alu_sequencer;
  import InstructionSetPkg::*;

  localparam int LAT = 4;

  typedef struct {
    logic [15:0] dest;
    sFlags       flags;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  eOperation   ReqOp;
  logic [15:0] ReqSrc;
  logic [15:0] ReqDest;
  logic [7:0]  ReqImm;
  logic        RspValid;
  logic        RspReady;
  logic [15:0] RspDest;
  sFlags       RspFlags;
  logic        RspError;
  logic        Flush;
  sFlags       Flags;
  logic        Busy;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  logic  manual_rdy = 1'b0;
  exp_t  exp_q[$];
  sFlags model_flags;
  sFlags prev_flags;
  logic [15:0] last_dest;
  logic        last_err;

  alu_sequencer #(.MulDivLatency(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqSrc(ReqSrc), .ReqDest(ReqDest), .ReqImm(ReqImm),
    .RspValid(RspValid), .RspReady(RspReady), .RspDest(RspDest),
    .RspFlags(RspFlags), .RspError(RspError), .Flush(Flush),
    .Flags(Flags), .Busy(Busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic int sx16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference behaviour from the ISA rules using plain integer arithmetic.
  function automatic exp_t model(input int op, input int src, input int dest, input int imm,
                                 input sFlags fin);
    exp_t   e;
    int     r, sr, si, r16;
    longint p;
    bit     known;
    e.flags = fin; e.err = 1'b0; e.lat = 1; e.acc = 0;
    known = 1'b1; r = 0; sr = 0;
    p = longint'(dest) * longint'(src);
    si = (imm > 127) ? imm - 256 : imm;
    case (op)
      0: begin
        r = dest + src + int'(fin.Carry);
        sr = sx16(dest) + sx16(src) + int'(fin.Carry);
        e.flags.Carry = (r > 65535);
        e.flags.Overflow = (sr > 32767) || (sr < -32768);
      end
      1: begin
        r = dest - src;
        sr = sx16(dest) - sx16(src);
        e.flags.Carry = (dest < src);
        e.flags.Overflow = (sr > 32767) || (sr < -32768);
      end
      2: begin
        r = dest + (si & 'hFFFF);
        sr = sx16(dest) + si;
        e.flags.Carry = (r > 65535);
        e.flags.Overflow = (sr > 32767) || (sr < -32768);
      end
      3: r = dest & src;
      4: r = dest | src;
      5: r = dest ^ src;
      6: r = src;
      7, 8: begin
        r = (op == 7) ? int'(p % 65536) : int'(p / 65536);
        e.flags.Carry = 1'b0; e.flags.Overflow = 1'b0; e.lat = LAT;
      end
      9, 10: begin
        if (src == 0) begin
          e.err = 1'b1; known = 1'b0; r = 0;
        end else begin
          r = (op == 9) ? dest / src : dest % src;
          e.flags.Carry = 1'b0; e.flags.Overflow = 1'b0; e.lat = LAT;
        end
      end
      default: begin known = 1'b0; r = 0; end
    endcase
    r16 = r & 'hFFFF;
    if (known) begin
      e.flags.Negative = (r16 >= 32768);
      e.flags.Zero = (r16 == 0);
    end
    e.dest = 16'(r16);
    return e;
  endfunction

  task automatic issue(input int op, input int src, input int dest, input int imm,
                       output int acc, output int lat);
    exp_t e;
    bit   ok;
    ReqOp = eOperation'(op[3:0]);
    ReqSrc = src[15:0];
    ReqDest = dest[15:0];
    ReqImm = imm[7:0];
    ReqValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge Clock); #2;
      ok = ReqReady;
      @(posedge Clock); #1;
    end
    ReqValid = 1'b0;
    acc = cyc;
    lat = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
    end else begin
      e = model(op, src, dest, imm, model_flags);
      e.acc = acc;
      lat = e.lat;
      exp_q.push_back(e);
      prev_flags = model_flags;
      if (!e.err) model_flags = e.flags;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || RspValid) && n < 100) begin
      @(posedge Clock); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(RspValid), 0);
    chk({tag, "_rsp_dest"}, 32'(RspDest), 0);
    chk({tag, "_rsp_err"}, 32'(RspError), 0);
    chk({tag, "_rsp_flags"}, 32'(RspFlags), 0);
    chk({tag, "_flags"}, 32'(Flags), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_req_ready"}, 32'(ReqReady), 1);
  endtask

  initial begin
    forever begin
      @(posedge Clock); #1;
      case (rdy_mode)
        0:       RspReady = 1'b1;
        1:       RspReady = ($urandom_range(0, 3) != 0);
        default: RspReady = manual_rdy;
      endcase
    end
  end

  // Monitor: compares each new response with the scoreboard head and checks it holds while stalled.
  initial begin
    exp_t cur;
    bit   holding = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        holding = 1'b0;
      end else if (RspValid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: dest %0h err %0b", RspDest, RspError);
            cur.dest = RspDest; cur.flags = RspFlags; cur.err = RspError;
          end else begin
            cur = exp_q[0];
            chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
            chk("rsp_dest", 32'(RspDest), 32'(cur.dest));
            chk("rsp_flags", 32'(RspFlags), 32'(cur.flags));
            chk("rsp_error", 32'(RspError), 32'(cur.err));
          end
          last_dest = RspDest;
          last_err = RspError;
          holding = 1'b1;
        end else begin
          chk("hold_dest", 32'(RspDest), 32'(cur.dest));
          chk("hold_flags", 32'(RspFlags), 32'(cur.flags));
          chk("hold_error", 32'(RspError), 32'(cur.err));
        end
        if (RspReady) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          holding = 1'b0;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    a1, a2, l;
    sFlags f;
    Reset = 1'b1; ReqValid = 1'b0; ReqOp = OP_ADC; ReqSrc = '0; ReqDest = '0; ReqImm = '0;
    Flush = 1'b0; RspReady = 1'b1;
    model_flags = '0; prev_flags = '0;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check_idle_outputs("reset");

    // Signed overflow into the sign bit.
    @(posedge Clock); #1;
    issue(OP_ADC, 16'h7FFF, 16'h0001, 0, a1, l);
    drain();
    f = '0; f.Negative = 1'b1; f.Overflow = 1'b1;
    chk("adc_dest", 32'(last_dest), 32'h8000);
    chk("adc_flags", 32'(Flags), 32'(f));

    // Back-to-back: second request accepted on the response handshake edge.
    issue(OP_SUB, 5, 5, 0, a1, l);
    issue(OP_ADC, 2, 1, 0, a2, l);
    chk("b2b_accept_gap", 32'(a2 - a1), 2);
    drain();
    chk("b2b_second_dest", 32'(last_dest), 3);

    // Multi-cycle op with a stalled consumer.
    rdy_mode = 2; manual_rdy = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    issue(OP_MUL, 7, 3, 0, a1, l);
    repeat (7) @(posedge Clock);
    manual_rdy = 1'b1;
    #1;
    drain();
    chk("mul_dest", 32'(last_dest), 21);
    rdy_mode = 0;

    // Divide by zero with Carry set beforehand.
    issue(OP_SUB, 1, 0, 0, a1, l);
    drain();
    chk("pre_div_carry", 32'(Flags.Carry), 1);
    issue(OP_DIV, 0, 100, 0, a1, l);
    drain();
    chk("div0_err", 32'(last_err), 1);
    chk("div0_dest", 32'(last_dest), 0);
    chk("div0_flags_kept", 32'(Flags), 32'(model_flags));

    // Flush in the second WAIT cycle.
    issue(OP_DIV, 7, 100, 0, a1, l);
    @(posedge Clock); #1 Flush = 1'b1;
    #1 chk("flush_blocks_ready", 32'(ReqReady), 0);
    @(posedge Clock); #1 Flush = 1'b0;
    void'(exp_q.pop_back());
    model_flags = prev_flags;
    @(negedge Clock);
    chk("flush_busy", 32'(Busy), 0);
    chk("flush_rsp_valid", 32'(RspValid), 0);
    chk("flush_flags", 32'(Flags), 32'(model_flags));
    repeat (6) @(posedge Clock);
    #1;
    issue(OP_MOVE, 16'h1234, 0, 0, a1, l);
    drain();
    chk("move_after_flush", 32'(last_dest), 32'h1234);

    // Unassigned opcode.
    issue(13, 5, 9, 0, a1, l);
    drain();
    chk("unknown_dest", 32'(last_dest), 0);
    chk("unknown_flags", 32'(Flags), 32'(model_flags));

    // Reset while waiting on a multiply.
    issue(OP_MUL, 3, 3, 0, a1, l);
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock); #1 Reset = 1'b0;
    void'(exp_q.pop_back());
    model_flags = '0;
    @(negedge Clock);
    check_idle_outputs("midop_reset");
    repeat (6) @(posedge Clock);
    #1;

    // Randomized traffic with random consumer stalls and occasional flushes.
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      int op, src, dest, imm;
      op = $urandom_range(0, 15);
      src = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
      dest = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 65535);
      imm = $urandom_range(0, 255);
      issue(op, src, dest, imm, a1, l);
      if (l > 1 && $urandom_range(0, 7) == 0) begin
        @(posedge Clock); #1 Flush = 1'b1;
        @(posedge Clock); #1 Flush = 1'b0;
        void'(exp_q.pop_back());
        model_flags = prev_flags;
      end else begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge Clock); #1;
        end
      end
    end
    rdy_mode = 0;
    @(posedge Clock); #1;
    drain();
    chk("final_flags", 32'(Flags), 32'(model_flags));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MulDivLatency, default InstructionSetPkg::MulDivLatency (4), meaning cycles from accept to result for MUL/MUH/DIV/MOD (legal range 2..15).
REQ-002 SHALL have ports: Clock  in  1  sole clock, rising edge; Reset  in  1  synchronous, active-high.
REQ-003 SHALL have request ports: ReqValid in 1; ReqReady out 1; ReqOp in eOperation; ReqSrc in DataWidth; ReqDest in DataWidth; ReqImm in ImmediateWidth.
REQ-004 SHALL have response ports: RspValid out 1; RspReady in 1; RspDest out DataWidth result; RspFlags out sFlags post-op flags; RspError out 1 divide-by-zero.
REQ-005 SHALL have Flush in 1 (abort in-flight op); Flags out sFlags (architectural flag register); Busy out 1 (state != IDLE).

Function
REQ-006 SHALL implement states IDLE, EXEC, WAIT, RESP.
REQ-007 SHALL drive ReqReady = (IDLE) or (RESP and RspReady) and not Flush; accept = ReqValid and ReqReady at a rising edge.
REQ-008 On accept SHALL latch ReqOp/ReqSrc/ReqDest/ReqImm into operand registers held stable until next accept.
REQ-009 SHALL present latched operands and Flags as InFlags to one combinational ALU instance; ALU outputs are captured only at completion edges.
REQ-010 Single-cycle ops (all except MUL/MUH/DIV/MOD): accept -> EXEC; next edge captures OutDest/OutFlags -> RESP; RspValid high one cycle after accept edge.
REQ-011 MUL/MUH/DIV/MOD: accept -> WAIT with down-counter loaded MulDivLatency-1; capture at counter 0 edge -> RESP; RspValid high MulDivLatency cycles after accept edge.
REQ-012 DIV/MOD with latched Src == 0 SHALL go accept -> EXEC -> RESP, RspDest = 0, RspError = 1, RspFlags = Flags, flag register unchanged.
REQ-013 At every non-error capture edge the flag register SHALL load the ALU OutFlags; Flags output mirrors the register.
REQ-014 RspValid, RspDest, RspFlags, RspError SHALL be held stable in RESP until RspValid and RspReady; then IDLE, or EXEC/WAIT if a new request is accepted the same edge (back-to-back).
REQ-015 Unknown opcode SHALL complete as single-cycle with RspDest = 0, flags unchanged, RspError = 0.
REQ-016 Flush SHALL force IDLE at the next edge from any state, clearing RspValid, discarding in-flight result, and leaving the flag register untouched; Flush beats completion and accept on the same edge.
REQ-017 ReqValid while not ReqReady SHALL have no effect; request fields are don't-care when ReqValid low.

Reset
REQ-018 With Reset high at an edge: state IDLE, counter 0, operand registers 0, RspValid 0, RspDest 0, RspError 0, RspFlags 0, flag register 0, Busy 0; Reset beats Flush and accept.
REQ-019 Reset mid-operation SHALL discard the operation with no response; ReqReady high the first cycle after Reset deasserts.

Structure
REQ-020 MulDivLatency default and the state enum eSeqState SHALL live in InstructionSetPkg next to eOperation, sFlags, DataWidth, ImmediateWidth.
REQ-021 SHALL instantiate exactly one ArithmeticLogicUnit as its datapath sub-module; sequencing, counter, flag and response registers are local.

Verification (DataWidth = 16)
REQ-022 ADC Src=16'h7FFF Dest=16'h0001, Flags=0 -> RspDest=16'h8000, N=1, V=1, Z=0, C=0, RspValid 1 cycle after accept; Flags updated.
REQ-023 SUB Dest=5 Src=5 then immediate ADC accepted on RspReady edge -> first RspDest=0 Z=1; second accepted same edge, no idle cycle.
REQ-024 MUL Dest=3 Src=7, RspReady low 3 cycles -> RspValid exactly 4 cycles after accept, RspDest=21 held stable until RspReady.
REQ-025 DIV Dest=100 Src=0 with Flags.Carry=1 -> RspDest=0, RspError=1, RspFlags.Carry=1, flag register unchanged.
REQ-026 DIV Dest=100 Src=7, Flush in 2nd WAIT cycle -> no RspValid, IDLE next cycle, Flags unchanged; following MOVE Src=16'h1234 returns 16'h1234.
REQ-027 Reset asserted in WAIT -> all outputs at reset values next cycle, no response emitted.
